btn_irq_conditioner: RTL and testbench

BTN_IRQ_CONDITIONER -- requirements
Module: btn_irq_conditioner

---
 rtl/btn_irq_conditioner.sv | 167 ++++++++++++++++
 tb/tb_btn_irq_conditioner.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_irq_conditioner.sv
// -----------------------------------------------------------------------------
// btn_irq_conditioner
//
// Conditions 16 asynchronous push-button pins and one external interrupt pin
// for the core. Each pin is synchronized with two flops and then debounced on a
// slow sample tick. A level is accepted only when three consecutive tick
// samples agree. A debounced rising edge on the interrupt pin sets a pending
// interrupt. When BTN_IRQ_EN is non-zero, a debounced rising edge on any button
// also sets it. The core clears the pending interrupt with irq_ack.
//
// Parameters
//   DEBOUNCE_CYCLES  clk cycles per debounce sample tick (>= 2)
//   BTN_IRQ_EN       non-zero: debounced button rising edges raise the interrupt
//
// Ports
//   clk           in   system clock; all state changes on its rising edge
//   rst           in   asynchronous active-low reset (0 = reset)
//   btn_raw[15:0] in   asynchronous push-button pins
//   irq_raw       in   asynchronous external interrupt pin
//   irq_ack       in   one-cycle pulse from the core; clears the pending interrupt
//   btn_out[15:0] out  debounced button levels
//   btn_changed   out  one-cycle pulse in the first cycle btn_out shows a new value
//   interrupt     out  pending interrupt level
//   irq_overflow  out  sticky: a source edge arrived while one was already pending
// -----------------------------------------------------------------------------
module btn_irq_conditioner #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int BTN_IRQ_EN      = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] btn_raw,
    input  logic        irq_raw,
    input  logic        irq_ack,
    output logic [15:0] btn_out,
    output logic        btn_changed,
    output logic        interrupt,
    output logic        irq_overflow
);

    localparam int             CW       = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic           BTN_SRC  = (BTN_IRQ_EN != 0);

    // Bit 16 carries the interrupt pin; bits 15:0 carry the buttons.
    logic [16:0]   raw_s;
    logic [16:0]   sync1_r;
    logic [16:0]   sync2_r;
    logic [16:0]   hist0_r;
    logic [16:0]   hist1_r;
    logic [16:0]   deb_r;
    logic [16:0]   deb_nxt_s;
    logic [16:0]   agree_s;
    logic [16:0]   rise_s;
    logic [CW-1:0] cnt_r;
    logic          tick_s;
    logic          src_s;
    logic          chg_nxt_s;
    logic          chg_r;
    logic          pend_r;
    logic          ovf_r;

    assign raw_s  = {irq_raw, btn_raw};
    assign tick_s = (cnt_r == CNT_LAST);

    // Two-flop synchronizer for every raw pin.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= 17'h0_0000;
            sync2_r <= 17'h0_0000;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Free-running sample tick counter, wraps after DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (tick_s) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    // Two-deep sample history, shifted once per tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist0_r <= 17'h0_0000;
            hist1_r <= 17'h0_0000;
        end else if (tick_s) begin
            hist0_r <= sync2_r;
            hist1_r <= hist0_r;
        end else begin
            hist0_r <= hist0_r;
            hist1_r <= hist1_r;
        end
    end

    // Next debounced value. The two history samples and the current sample
    // must all agree on a tick before a bit may move.
    always_comb begin
        agree_s   = ~(hist1_r ^ hist0_r) & ~(hist0_r ^ sync2_r);
        deb_nxt_s = deb_r;
        if (tick_s) begin
            deb_nxt_s = (agree_s & sync2_r) | (~agree_s & deb_r);
        end else begin
            deb_nxt_s = deb_r;
        end
    end

    // Interrupt source and change detection, both derived from the update that
    // the next edge commits, so they line up with the new debounced value.
    // Several edges inside one tick collapse into the single src_s bit.
    always_comb begin
        rise_s    = deb_nxt_s & ~deb_r;
        chg_nxt_s = (deb_nxt_s[15:0] != deb_r[15:0]);
        if (BTN_SRC) begin
            src_s = rise_s[16] | (|rise_s[15:0]);
        end else begin
            src_s = rise_s[16];
        end
    end

    // Debounced levels and the registered change pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_r <= 17'h0_0000;
            chg_r <= 1'b0;
        end else begin
            deb_r <= deb_nxt_s;
            chg_r <= chg_nxt_s;
        end
    end

    // Pending interrupt: a new source edge beats a simultaneous acknowledge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_r <= 1'b0;
        end else if (src_s) begin
            pend_r <= 1'b1;
        end else if (irq_ack) begin
            pend_r <= 1'b0;
        end else begin
            pend_r <= pend_r;
        end
    end

    // Sticky overflow: an edge landed on an un-acknowledged pending interrupt.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_r <= 1'b0;
        end else if (src_s && pend_r && !irq_ack) begin
            ovf_r <= 1'b1;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign btn_out      = deb_r[15:0];
    assign btn_changed  = chg_r;
    assign interrupt    = pend_r;
    assign irq_overflow = ovf_r;

endmodule

// File: tb/tb_btn_irq_conditioner.sv
// -----------------------------------------------------------------------------
// Directed bench for btn_irq_conditioner with DEBOUNCE_CYCLES = 4.
// Instance a: BTN_IRQ_EN = 0. Instance b: BTN_IRQ_EN = 1.
// cyc counts rising edges since reset release. Edges with cyc a multiple of 4
// (from 4 on) are tick edges. A raw change applied just after edge k is
// accepted on edge T+8, where T is the first multiple of 4 that is >= k+3.
// -----------------------------------------------------------------------------
module tb_btn_irq_conditioner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] a_btn_raw = 16'h0000;
    logic        a_irq_raw = 1'b0;
    logic        a_ack     = 1'b0;
    logic [15:0] a_btn_out;
    logic        a_chg, a_int, a_ovf;
    logic [15:0] b_btn_raw = 16'h0000;
    logic        b_irq_raw = 1'b0;
    logic        b_ack     = 1'b0;
    logic [15:0] b_btn_out;
    logic        b_chg, b_int, b_ovf;

    int cyc    = 0;
    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    btn_irq_conditioner #(.DEBOUNCE_CYCLES(4), .BTN_IRQ_EN(0)) u_a (
        .clk(clk), .rst(rst), .btn_raw(a_btn_raw), .irq_raw(a_irq_raw), .irq_ack(a_ack),
        .btn_out(a_btn_out), .btn_changed(a_chg), .interrupt(a_int), .irq_overflow(a_ovf)
    );

    btn_irq_conditioner #(.DEBOUNCE_CYCLES(4), .BTN_IRQ_EN(1)) u_b (
        .clk(clk), .rst(rst), .btn_raw(b_btn_raw), .irq_raw(b_irq_raw), .irq_ack(b_ack),
        .btn_out(b_btn_out), .btn_changed(b_chg), .interrupt(b_int), .irq_overflow(b_ovf)
    );

    task automatic step;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset;
        a_btn_raw = 16'h0000; a_irq_raw = 1'b0; a_ack = 1'b0;
        b_btn_raw = 16'h0000; b_irq_raw = 1'b0; b_ack = 1'b0;
        rst = 1'b0;
        step;
        step;
        rst = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset;
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (a_btn_out !== 16'h0000) begin n_fail++; $display("FAIL reset_a_btn_out: got %h want %h", a_btn_out, 16'h0000); end
        n_cmp++; if (a_chg !== 1'b0) begin n_fail++; $display("FAIL reset_a_changed: got %b want 0", a_chg); end
        n_cmp++; if (a_int !== 1'b0) begin n_fail++; $display("FAIL reset_a_interrupt: got %b want 0", a_int); end
        n_cmp++; if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_a_overflow: got %b want 0", a_ovf); end
        n_cmp++; if (b_btn_out !== 16'h0000) begin n_fail++; $display("FAIL reset_b_btn_out: got %h want %h", b_btn_out, 16'h0000); end
        n_cmp++; if (b_int !== 1'b0) begin n_fail++; $display("FAIL reset_b_interrupt: got %b want 0", b_int); end
    endtask

    task automatic test_glitch;
        int bad_out = 0;
        int bad_chg = 0;
        do_reset;
        while (cyc < 40) begin
            if (cyc == 5)  a_btn_raw = 16'h0008;
            if (cyc == 10) a_btn_raw = 16'h0000;
            step;
            if (a_btn_out !== 16'h0000) bad_out++;
            if (a_chg !== 1'b0) bad_chg++;
        end
        n_cmp++; if (bad_out != 0) begin n_fail++; $display("FAIL glitch_btn_out: got %0d moved cycles want 0 (last %h)", bad_out, a_btn_out); end
        n_cmp++; if (bad_chg != 0) begin n_fail++; $display("FAIL glitch_changed: got %0d pulses want 0", bad_chg); end
    endtask

    task automatic test_accept;
        int pulses = 0;
        int ints   = 0;
        do_reset;
        while (cyc < 40) begin
            if (cyc == 10) a_btn_raw = 16'h0001;
            step;
            if (a_chg === 1'b1) pulses++;
            if (a_int !== 1'b0) ints++;
            if (cyc == 23) begin
                n_cmp++; if (a_btn_out !== 16'h0000) begin n_fail++; $display("FAIL accept_early: got %h want %h", a_btn_out, 16'h0000); end
            end
            if (cyc == 24) begin
                n_cmp++; if (a_btn_out !== 16'h0001) begin n_fail++; $display("FAIL accept_btn_out: got %h want %h", a_btn_out, 16'h0001); end
                n_cmp++; if (a_chg !== 1'b1) begin n_fail++; $display("FAIL accept_changed: got %b want 1", a_chg); end
            end
            if (cyc == 25) begin
                n_cmp++; if (a_chg !== 1'b0) begin n_fail++; $display("FAIL accept_changed_drop: got %b want 0", a_chg); end
            end
        end
        n_cmp++; if (pulses != 1) begin n_fail++; $display("FAIL accept_pulse_count: got %0d want 1", pulses); end
        n_cmp++; if (ints != 0) begin n_fail++; $display("FAIL accept_no_irq: got %0d cycles want 0", ints); end
    endtask

    task automatic test_irq;
        int ints = 0;
        int chg  = 0;
        do_reset;
        a_irq_raw = 1'b1;
        while (cyc < 50) begin
            step;
            if (cyc == 11) begin
                n_cmp++; if (a_int !== 1'b0) begin n_fail++; $display("FAIL irq_early: got %b want 0", a_int); end
            end
            if (cyc == 12) begin
                n_cmp++; if (a_int !== 1'b1) begin n_fail++; $display("FAIL irq_set: got %b want 1", a_int); end
                n_cmp++; if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL irq_no_ovf: got %b want 0", a_ovf); end
                a_ack = 1'b1;
            end
            if (cyc == 13) begin
                a_ack = 1'b0;
                n_cmp++; if (a_int !== 1'b0) begin n_fail++; $display("FAIL irq_ack_clear: got %b want 0", a_int); end
            end
            if (cyc > 13 && a_int !== 1'b0) ints++;
            if (a_chg !== 1'b0) chg++;
        end
        n_cmp++; if (ints != 0) begin n_fail++; $display("FAIL irq_held_no_retrigger: got %0d cycles want 0", ints); end
        n_cmp++; if (chg != 0) begin n_fail++; $display("FAIL irq_no_btn_changed: got %0d want 0", chg); end
    endtask

    task automatic test_overflow;
        do_reset;
        a_irq_raw = 1'b1;
        while (cyc < 64) begin
            if (cyc == 12) a_irq_raw = 1'b0;
            if (cyc == 24) a_irq_raw = 1'b1;
            if (cyc == 35) a_ack = 1'b1;
            if (cyc == 36) begin a_ack = 1'b0; a_irq_raw = 1'b0; end
            if (cyc == 48) a_irq_raw = 1'b1;
            if (cyc == 60) a_ack = 1'b1;
            if (cyc == 61) a_ack = 1'b0;
            step;
            if (cyc == 36) begin
                n_cmp++; if (a_int !== 1'b1) begin n_fail++; $display("FAIL same_cycle_set_wins: got %b want 1", a_int); end
                n_cmp++; if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL same_cycle_no_ovf: got %b want 0", a_ovf); end
            end
            if (cyc == 37) begin
                n_cmp++; if (a_int !== 1'b1) begin n_fail++; $display("FAIL same_cycle_hold: got %b want 1", a_int); end
            end
            if (cyc == 59) begin
                n_cmp++; if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b want 0", a_ovf); end
            end
            if (cyc == 60) begin
                n_cmp++; if (a_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", a_ovf); end
                n_cmp++; if (a_int !== 1'b1) begin n_fail++; $display("FAIL ovf_int_held: got %b want 1", a_int); end
            end
            if (cyc == 61) begin
                n_cmp++; if (a_int !== 1'b0) begin n_fail++; $display("FAIL ovf_ack_clear: got %b want 0", a_int); end
            end
        end
        n_cmp++; if (a_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", a_ovf); end
    endtask

    task automatic test_btn_irq;
        do_reset;
        b_btn_raw = 16'h8000;
        while (cyc < 32) begin
            if (cyc == 12) b_ack = 1'b1;
            if (cyc == 13) b_ack = 1'b0;
            if (cyc == 14) b_btn_raw = 16'h0000;
            step;
            if (cyc == 11) begin
                n_cmp++; if (b_int !== 1'b0) begin n_fail++; $display("FAIL btnirq_early: got %b want 0", b_int); end
            end
            if (cyc == 12) begin
                n_cmp++; if (b_btn_out !== 16'h8000) begin n_fail++; $display("FAIL btnirq_btn_out: got %h want %h", b_btn_out, 16'h8000); end
                n_cmp++; if (b_int !== 1'b1) begin n_fail++; $display("FAIL btnirq_int: got %b want 1", b_int); end
                n_cmp++; if (b_chg !== 1'b1) begin n_fail++; $display("FAIL btnirq_changed: got %b want 1", b_chg); end
            end
            if (cyc == 13) begin
                n_cmp++; if (b_int !== 1'b0) begin n_fail++; $display("FAIL btnirq_ack: got %b want 0", b_int); end
            end
            if (cyc == 28) begin
                n_cmp++; if (b_btn_out !== 16'h0000) begin n_fail++; $display("FAIL btnirq_fall_out: got %h want %h", b_btn_out, 16'h0000); end
                n_cmp++; if (b_chg !== 1'b1) begin n_fail++; $display("FAIL btnirq_fall_changed: got %b want 1", b_chg); end
                n_cmp++; if (b_int !== 1'b0) begin n_fail++; $display("FAIL btnirq_fall_no_int: got %b want 0", b_int); end
            end
        end
    endtask

    task automatic test_reset_mid;
        do_reset;
        a_btn_raw = 16'h0004;
        while (cyc < 9) step;
        #1;
        rst = 1'b0;
        #2;
        rst = 1'b1;
        cyc = 0;
        while (cyc < 14) begin
            step;
            if (cyc == 11) begin
                n_cmp++; if (a_btn_out !== 16'h0000) begin n_fail++; $display("FAIL midreset_history_kept: got %h want %h", a_btn_out, 16'h0000); end
            end
            if (cyc == 12) begin
                n_cmp++; if (a_btn_out !== 16'h0004) begin n_fail++; $display("FAIL midreset_accept: got %h want %h", a_btn_out, 16'h0004); end
            end
        end
    endtask

    task automatic test_reset_async;
        int pulses = 0;
        do_reset;
        b_btn_raw = 16'hFFFF;
        while (cyc < 12) step;
        n_cmp++; if (b_btn_out !== 16'hFFFF) begin n_fail++; $display("FAIL async_pre_out: got %h want %h", b_btn_out, 16'hFFFF); end
        n_cmp++; if (b_int !== 1'b1) begin n_fail++; $display("FAIL async_pre_int: got %b want 1", b_int); end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (b_btn_out !== 16'h0000) begin n_fail++; $display("FAIL async_clear_out: got %h want %h", b_btn_out, 16'h0000); end
        n_cmp++; if (b_chg !== 1'b0) begin n_fail++; $display("FAIL async_clear_changed: got %b want 0", b_chg); end
        n_cmp++; if (b_int !== 1'b0) begin n_fail++; $display("FAIL async_clear_int: got %b want 0", b_int); end
        #1;
        rst = 1'b1;
        cyc = 0;
        while (cyc < 30) begin
            step;
            if (b_chg === 1'b1) pulses++;
            if (cyc == 11) begin
                n_cmp++; if (b_btn_out !== 16'h0000) begin n_fail++; $display("FAIL async_reaccept_early: got %h want %h", b_btn_out, 16'h0000); end
            end
            if (cyc == 12) begin
                n_cmp++; if (b_btn_out !== 16'hFFFF) begin n_fail++; $display("FAIL async_reaccept_out: got %h want %h", b_btn_out, 16'hFFFF); end
                n_cmp++; if (b_int !== 1'b1) begin n_fail++; $display("FAIL async_reaccept_int: got %b want 1", b_int); end
            end
        end
        n_cmp++; if (pulses != 1) begin n_fail++; $display("FAIL async_pulse_count: got %0d want 1", pulses); end
    endtask

    initial begin
        test_reset;
        test_glitch;
        test_accept;
        test_irq;
        test_overflow;
        test_btn_irq;
        test_reset_mid;
        test_reset_async;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
